// File: rtl/cht_shift_ctrl.sv
// Round-robin two-port sequencer for the shift-chain datapath: grants one
// command at a time and holds the chosen chain select for the requested length.
module cht_shift_ctrl #(
   parameter int CNT_W = 5
) (
   input  logic             clk_pad,
   input  logic             rst_n_pad,
   input  logic             req0_valid_pad,
   input  logic [1:0]       req0_op_pad,
   input  logic [CNT_W-1:0] req0_len_pad,
   output logic             req0_ready_pad,
   input  logic             req1_valid_pad,
   input  logic [1:0]       req1_op_pad,
   input  logic [CNT_W-1:0] req1_len_pad,
   output logic             req1_ready_pad,
   input  logic             cfg_p_pad,
   input  logic             abort_pad,
   output logic             i_pad,
   output logic             j_pad,
   output logic             k_pad,
   output logic             p_pad,
   output logic             l_pad,
   output logic             busy_pad,
   output logic             done_pad,
   output logic             aborted_pad,
   output logic             grant_id_pad
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic             last_grant, last_grant_n;
   logic             grant_id, grant_id_n;
   logic             i_q, j_q, k_q, p_q, l_q;
   logic             i_n, j_n, k_n, p_n, l_n;
   logic             aborted_q, aborted_n;
   logic             hs, win;
   logic [1:0]       op;
   logic [CNT_W-1:0] len;

   // Ready is offered only in IDLE and never while reset is asserted.
   always_comb begin
      req0_ready_pad = rst_n_pad && (state == IDLE) && req0_valid_pad &&
                       (!req1_valid_pad || last_grant);
      req1_ready_pad = rst_n_pad && (state == IDLE) && req1_valid_pad &&
                       (!req0_valid_pad || !last_grant);
      hs  = req0_ready_pad || req1_ready_pad;
      win = req1_ready_pad;
      op  = win ? req1_op_pad  : req0_op_pad;
      len = win ? req1_len_pad : req0_len_pad;
   end

   always_comb begin
      state_n      = state;
      cnt_n        = cnt;
      last_grant_n = last_grant;
      grant_id_n   = grant_id;
      i_n          = i_q;
      j_n          = j_q;
      k_n          = k_q;
      p_n          = p_q;
      l_n          = l_q;
      aborted_n    = aborted_q;
      case (state)
         IDLE: begin
            aborted_n = 1'b0;
            if (hs) begin
               last_grant_n = win;
               grant_id_n   = win;
               if (op == 2'b00) begin
                  l_n     = 1'b1;
                  cnt_n   = CNT_W'(1);
                  state_n = RUN;
               end else if (len != '0) begin
                  i_n     = (op == 2'b01);
                  j_n     = (op == 2'b10);
                  k_n     = (op == 2'b11);
                  p_n     = (op == 2'b11) && cfg_p_pad;
                  cnt_n   = len;
                  state_n = RUN;
               end else begin
                  state_n = DONE;
               end
            end
         end
         RUN: begin
            if (abort_pad || cnt == CNT_W'(1)) begin
               i_n       = 1'b0;
               j_n       = 1'b0;
               k_n       = 1'b0;
               p_n       = 1'b0;
               l_n       = 1'b0;
               cnt_n     = '0;
               aborted_n = abort_pad && (cnt != CNT_W'(1));
               state_n   = DONE;
            end else begin
               cnt_n = cnt - CNT_W'(1);
            end
         end
         DONE: begin
            aborted_n = 1'b0;
            state_n   = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk_pad) begin
      if (!rst_n_pad) begin
         state      <= IDLE;
         cnt        <= '0;
         last_grant <= 1'b1;
         grant_id   <= 1'b0;
         i_q        <= 1'b0;
         j_q        <= 1'b0;
         k_q        <= 1'b0;
         p_q        <= 1'b0;
         l_q        <= 1'b0;
         aborted_q  <= 1'b0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         last_grant <= last_grant_n;
         grant_id   <= grant_id_n;
         i_q        <= i_n;
         j_q        <= j_n;
         k_q        <= k_n;
         p_q        <= p_n;
         l_q        <= l_n;
         aborted_q  <= aborted_n;
      end
   end

   assign i_pad        = i_q;
   assign j_pad        = j_q;
   assign k_pad        = k_q;
   assign p_pad        = p_q;
   assign l_pad        = l_q;
   assign busy_pad     = (state != IDLE);
   assign done_pad     = (state == DONE);
   assign aborted_pad  = aborted_q;
   assign grant_id_pad = grant_id;

endmodule

// File: tb/tb_cht_shift_ctrl.sv
// Directed bench for cht_shift_ctrl: per-command cycle histograms checked
// against hand-computed select lengths, done position and arbitration order.
module tb_cht_shift_ctrl;

   localparam int CNT_W = 5;

   logic             clk_pad = 1'b0;
   logic             rst_n_pad;
   logic             req0_valid_pad, req1_valid_pad;
   logic [1:0]       req0_op_pad, req1_op_pad;
   logic [CNT_W-1:0] req0_len_pad, req1_len_pad;
   logic             req0_ready_pad, req1_ready_pad;
   logic             cfg_p_pad, abort_pad;
   logic             i_pad, j_pad, k_pad, p_pad, l_pad;
   logic             busy_pad, done_pad, aborted_pad, grant_id_pad;

   int checks = 0;
   int errors = 0;

   int ni, nj, nk, np, nl, nbusy, nrdy, ndone, done_cyc, ab, bad;
   int abort_at = 0;
   int rst_at   = 0;
   bit hold1    = 1'b0;

   cht_shift_ctrl #(.CNT_W(CNT_W)) dut (
      .clk_pad(clk_pad), .rst_n_pad(rst_n_pad),
      .req0_valid_pad(req0_valid_pad), .req0_op_pad(req0_op_pad),
      .req0_len_pad(req0_len_pad), .req0_ready_pad(req0_ready_pad),
      .req1_valid_pad(req1_valid_pad), .req1_op_pad(req1_op_pad),
      .req1_len_pad(req1_len_pad), .req1_ready_pad(req1_ready_pad),
      .cfg_p_pad(cfg_p_pad), .abort_pad(abort_pad),
      .i_pad(i_pad), .j_pad(j_pad), .k_pad(k_pad), .p_pad(p_pad), .l_pad(l_pad),
      .busy_pad(busy_pad), .done_pad(done_pad), .aborted_pad(aborted_pad),
      .grant_id_pad(grant_id_pad)
   );

   always #5 clk_pad = ~clk_pad;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Inputs change and outputs are sampled 2 time units after each rising edge.
   task automatic tick();
      @(posedge clk_pad);
      #2;
   endtask

   task automatic outs_zero(input string tag);
      chk({tag, " ctl"}, int'({i_pad, j_pad, k_pad, p_pad, l_pad}), 0);
      chk({tag, " stat"}, int'({busy_pad, done_pad, aborted_pad}), 0);
   endtask

   // Observe n cycles after a handshake, one histogram per output.
   task automatic observe(input int n);
      ni = 0; nj = 0; nk = 0; np = 0; nl = 0; nbusy = 0; nrdy = 0;
      ndone = 0; done_cyc = 0; ab = 0; bad = 0;
      for (int c = 1; c <= n; c++) begin
         abort_pad = (c == abort_at);
         rst_n_pad = !(c == rst_at);
         if (hold1) req1_valid_pad = busy_pad;
         #1;
         ni += int'(i_pad); nj += int'(j_pad); nk += int'(k_pad);
         np += int'(p_pad); nl += int'(l_pad); nbusy += int'(busy_pad);
         nrdy += int'(req0_ready_pad | req1_ready_pad);
         if (done_pad) begin
            ndone++;
            if (done_cyc == 0) begin
               done_cyc = c;
               ab = int'(aborted_pad);
            end
         end
         if ($countones({i_pad, j_pad, k_pad, l_pad}) > 1) bad++;
         if (p_pad && !k_pad) bad++;
         if (aborted_pad && !done_pad) bad++;
         tick();
      end
      abort_pad = 1'b0;
      rst_n_pad = 1'b1;
      abort_at  = 0;
      rst_at    = 0;
   endtask

   task automatic do_reset();
      rst_n_pad = 1'b0;
      req0_valid_pad = 1'b1;
      req1_valid_pad = 1'b1;
      #1;
      chk("rst ready", int'({req0_ready_pad, req1_ready_pad}), 0);
      tick();
      tick();
      outs_zero("rst");
      chk("rst grant", int'(grant_id_pad), 0);
      req0_valid_pad = 1'b0;
      req1_valid_pad = 1'b0;
      rst_n_pad = 1'b1;
   endtask

   task automatic set_req0(input logic [1:0] op, input int len);
      req0_valid_pad = 1'b1;
      req0_op_pad    = op;
      req0_len_pad   = CNT_W'(len);
   endtask

   task automatic set_req1(input logic [1:0] op, input int len);
      req1_valid_pad = 1'b1;
      req1_op_pad    = op;
      req1_len_pad   = CNT_W'(len);
   endtask

   initial begin
      rst_n_pad = 1'b0; abort_pad = 1'b0; cfg_p_pad = 1'b0;
      req0_valid_pad = 1'b0; req0_op_pad = 2'b00; req0_len_pad = '0;
      req1_valid_pad = 1'b0; req1_op_pad = 2'b00; req1_len_pad = '0;
      tick();
      do_reset();

      // single I shift, len 3
      set_req0(2'b01, 3);
      #1;
      chk("t1 ready", int'({req0_ready_pad, req1_ready_pad}), 2);
      tick();
      req0_valid_pad = 1'b0;
      chk("t1 grant", int'(grant_id_pad), 0);
      observe(4);
      chk("t1 i cycles", ni, 3);
      chk("t1 p cycles", np, 0);
      chk("t1 done at", done_cyc, 4);
      chk("t1 busy cycles", nbusy, 4);
      chk("t1 aborted", ab, 0);
      chk("t1 excl", bad, 0);
      outs_zero("t1 idle");

      // tie: req0 wins first after reset, then req1
      do_reset();
      cfg_p_pad = 1'b1;
      set_req0(2'b11, 2);
      set_req1(2'b10, 1);
      #1;
      chk("t2 tie0 ready", int'({req0_ready_pad, req1_ready_pad}), 2);
      tick();
      req0_valid_pad = 1'b0;
      cfg_p_pad = 1'b0;
      chk("t2 grant0", int'(grant_id_pad), 0);
      observe(3);
      chk("t2 k cycles", nk, 2);
      chk("t2 p cycles", np, 2);
      chk("t2 done at", done_cyc, 3);
      chk("t2 no ready busy", nrdy, 0);
      chk("t2 excl", bad, 0);
      #1;
      chk("t2 req1 ready", int'({req0_ready_pad, req1_ready_pad}), 1);
      tick();
      req1_valid_pad = 1'b0;
      chk("t2 grant1", int'(grant_id_pad), 1);
      observe(2);
      chk("t2 j cycles", nj, 1);
      chk("t2 j done at", done_cyc, 2);
      chk("t2 j p cycles", np, 0);
      set_req0(2'b01, 1);
      set_req1(2'b10, 1);
      #1;
      chk("t2 tie3 ready", int'({req0_ready_pad, req1_ready_pad}), 2);
      tick();
      req0_valid_pad = 1'b0;
      req1_valid_pad = 1'b0;
      chk("t2 grant3", int'(grant_id_pad), 0);
      observe(2);
      chk("t2 i cycles", ni, 1);

      // clear ignores len; zero-length shift goes straight to done
      set_req1(2'b00, 7);
      #1;
      chk("t3 clr ready", int'({req0_ready_pad, req1_ready_pad}), 1);
      tick();
      req1_valid_pad = 1'b0;
      observe(2);
      chk("t3 l cycles", nl, 1);
      chk("t3 clr sel", ni + nj + nk + np, 0);
      chk("t3 clr done at", done_cyc, 2);
      set_req0(2'b01, 0);
      tick();
      req0_valid_pad = 1'b0;
      observe(1);
      chk("t3 z done at", done_cyc, 1);
      chk("t3 z sel", ni + nj + nk + nl + np, 0);
      chk("t3 z busy", nbusy, 1);

      // abort in idle is ignored; abort in 4th run cycle of len 10
      abort_pad = 1'b1;
      tick();
      abort_pad = 1'b0;
      chk("t4 idle abort", int'({busy_pad, done_pad, aborted_pad}), 0);
      set_req0(2'b10, 10);
      tick();
      req0_valid_pad = 1'b0;
      abort_at = 4;
      observe(5);
      chk("t4 j cycles", nj, 4);
      chk("t4 done at", done_cyc, 5);
      chk("t4 aborted", ab, 1);
      chk("t4 excl", bad, 0);
      chk("t4 after", int'({busy_pad, done_pad, aborted_pad}), 0);

      // reset during 3rd cycle of a len 8 K shift
      set_req0(2'b11, 8);
      tick();
      req0_valid_pad = 1'b0;
      rst_at = 3;
      observe(4);
      chk("t5 k cycles", nk, 3);
      chk("t5 busy cycles", nbusy, 3);
      chk("t5 no done", ndone, 0);
      outs_zero("t5 post");
      chk("t5 grant", int'(grant_id_pad), 0);

      // tie after reset goes to req0: max length 31, req1 held during busy
      set_req0(2'b01, 31);
      set_req1(2'b10, 1);
      #1;
      chk("t6 tie ready", int'({req0_ready_pad, req1_ready_pad}), 2);
      tick();
      req0_valid_pad = 1'b0;
      hold1 = 1'b1;
      observe(32);
      hold1 = 1'b0;
      req1_valid_pad = 1'b0;
      chk("t6 i cycles", ni, 31);
      chk("t6 done at", done_cyc, 32);
      chk("t6 busy cycles", nbusy, 32);
      chk("t6 no ready busy", nrdy, 0);
      chk("t6 excl", bad, 0);
      #1;
      outs_zero("t6 idle");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cht_shift_ctrl.md
# cht_shift_ctrl

Sequencer and two-port arbiter for the shift-chain next-state datapath. It owns that datapath's control nets: chain selects `i_pad`, `j_pad`, `k_pad`, mode `p_pad` and synchronous clear `l_pad`. Two requesters each issue a command: clear all chains, or shift one chain a programmed number of steps. The controller grants requesters round-robin, then holds the matching select high for exactly the requested number of cycles.

## Interface
- `CNT_W`, default 5: width of the shift-length field; maximum run is 2^CNT_W-1 steps.
- `clk_pad` in 1: single clock; all state updates on the rising edge.
- `rst_n_pad` in 1: reset, synchronous and active-low.
- `req0_valid_pad` in 1: requester 0 has a command.
- `req0_op_pad` in 2: requester 0 opcode. 00 = clear, 01 = shift I-chain, 10 = shift J-chain, 11 = shift K-chain.
- `req0_len_pad` in CNT_W: requester 0 step count. Ignored for clear.
- `req0_ready_pad` out 1: requester 0 command accepted this cycle.
- `req1_valid_pad`, `req1_op_pad`, `req1_len_pad`, `req1_ready_pad`: same definitions for requester 1.
- `cfg_p_pad` in 1: K-chain mode, sampled at grant. 0 = normal K shift; 1 = load/hold mode.
- `abort_pad` in 1: terminate the current run.
- `i_pad`, `j_pad`, `k_pad`, `p_pad`, `l_pad` out 1 each: registered datapath controls.
- `busy_pad` out 1: high in RUN or DONE.
- `done_pad` out 1: one-cycle completion pulse.
- `aborted_pad` out 1: qualifies `done_pad`; high when the run ended by abort.
- `grant_id_pad` out 1: requester of the current or last command.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - `ready` is combinational. It goes to at most one requester: the arbitration winner among those with valid high.
  - Winner rule: on a single request, that requester wins. On simultaneous requests, the requester that is not `last_grant` wins.
  - On a handshake, `last_grant` and `grant_id_pad` update to the winner. Opcode, length and `cfg_p_pad` are latched.
  - The next state depends on the latched command:
    - Clear: `l_pad`=1 next cycle, and the state goes to RUN with count=1.
    - Shift with len>0: the select register for the chosen chain goes to 1, and the state goes to RUN with count=len.
    - For a K shift, `p_pad` = the latched `cfg_p_pad`. For I and J shifts, `p_pad`=0.
    - Shift with len=0: no select asserted; the state goes directly to DONE.
- RUN:
  - Exactly one of {`i_pad`, `j_pad`, `k_pad`, `l_pad`} is high.
  - The count decrements each cycle.
  - When count==1, or `abort_pad`=1, all control registers clear on the next edge and the state goes to DONE.
  - `aborted_pad` is set only when the abort ended the run with count>1.
  - Abort has no effect in IDLE or DONE.
- DONE:
  - `done_pad`=1 for one cycle; then the state returns to IDLE.
  - No `ready` is issued in DONE.
- Invariant: the control outputs are never high outside RUN. This includes `p_pad`.
- `last_grant` resets to 1, so requester 0 wins the first tie.

## Timing
- Reset: on a clock edge with `rst_n_pad`=0:
  - All outputs go to 0, including `ready` (forced low while in reset).
  - The state goes to IDLE, count to 0, `last_grant` to 1.
  - Reset mid-run aborts silently: no `done_pad` pulse.
- Handshake in cycle T with len=N>0:
  - Select is high for cycles T+1..T+N.
  - `done_pad` is high in cycle T+N+1.
  - The earliest next handshake is cycle T+N+2.
- Clear: `l_pad` is high in cycle T+1 only; `done_pad` is high in T+2.
- len=0: `done_pad` is high in T+1; no select pulse.
- Abort sampled high in RUN cycle T+k: select drops at T+k+1, and `done_pad` with `aborted_pad` is high in T+k+1.
- `busy_pad` is high from T+1 through the `done_pad` cycle inclusive.
- A requester holds valid, op and len stable until it sees `ready`. Changes while not ready are ignored.

## Test plan
- Reset then a single request: req0 {op=01, len=3} at T. `i_pad`=1 for T+1..T+3, `done_pad` at T+4, `grant_id_pad`=0, `p_pad`=0 throughout.
- Simultaneous requests: both valid; req0 {11, len=2, cfg_p=1}, req1 {10, len=1}.
  - req0 wins first: `k_pad`=`p_pad`=1 for 2 cycles.
  - Then req1: `j_pad`=1 for 1 cycle.
  - A third tie after that goes to req0.
- Clear and zero length:
  - req1 op=00 with len=7: `l_pad` high 1 cycle, `done_pad` 2 cycles after the handshake.
  - req0 {01, len=0}: no select, `done_pad` at T+1.
- Abort: req0 {10, len=10}, `abort_pad` pulsed in the 4th run cycle. `j_pad` high exactly 4 cycles; `done_pad`=`aborted_pad`=1 in the next cycle.
- Reset mid-run: `rst_n_pad` low during cycle 3 of a len=8 K shift. All outputs 0 the next cycle, no `done_pad`; the next tie grants req0.
- Maximum length: len=31 with CNT_W=5. Select high exactly 31 cycles, count never wraps, and ready stays 0 for the entire busy period.
